ysyx_22040088_divider: RTL and testbench
========================================

Name: ysyx_22040088_divider

Overview:
- Multi-cycle 32-bit integer divider for the RV64 W-form divide/remainder ops (divw, remw; divuw, remuw reserved via div_signed).
- Sits downstream of the control unit in the execute stage. The control unit's divw/remw alu_op bits and zero-extended word operands drive its request. Its sign-extended 64-bit result returns to the ALU result mux.
- Uses a radix-2 restoring algorithm with a valid/ready handshake, so the core stalls while a division is in progress.

Parameters:
- XLEN, 64, width of the result bus.
- WLEN, 32, operand width and number of iteration cycles.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- div_signed  input  1  1 = signed (divw/remw), 0 = unsigned.
- is_rem  input  1  1 = return remainder, 0 = return quotient.
- dividend  input  WLEN  rs1[31:0].
- divisor  input  WLEN  rs2[31:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- result  output  XLEN  selected quotient or remainder, sign-extended from bit 31.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, out_valid = 0, result = 0, counter = 0, internal registers = 0.
  - in_ready is 1 after reset because it is derived combinationally from state == IDLE.
- Accept: a request is accepted at edge E0 when in_valid & in_ready & ~flush.
  - The block latches div_signed, is_rem, the operand magnitudes, the quotient sign (sign(a)^sign(b), signed only) and the remainder sign (sign(a), signed only).
- States: IDLE, CALC, DONE.
- IDLE transitions at the accept edge:
  - divisor == 0 → DONE with quotient = all ones and remainder = dividend.
  - signed, dividend == 0x80000000 and divisor == 0xFFFFFFFF → DONE with quotient = 0x80000000 and remainder = 0.
  - Otherwise → CALC with counter = WLEN-1.
  - Special cases therefore raise out_valid after E0, a latency of 1 cycle.
- CALC iteration, one per edge:
  - Shift {rem, quo} left by 1, bringing in the next dividend bit.
  - trial = rem - |divisor| (33-bit).
  - If trial is non-negative: rem = trial, quotient bit = 1. Otherwise quotient bit = 0.
  - Decrement the counter.
  - The iteration at counter == 0 goes to DONE. CALC covers exactly 32 edges, E1..E32.
- Entering DONE:
  - Apply sign fixes: two's-complement negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Select the quotient or remainder by is_rem and sign-extend bit 31 to XLEN. This applies even for unsigned ops, per RV64 W semantics.
  - Register the value into result and set out_valid = 1.
  - Normal latency: out_valid is first high after E32.
- DONE:
  - out_valid and result are held stable while out_ready is low.
  - When out_valid & out_ready is sampled, go to IDLE and clear out_valid. result keeps its last value.
  - No back-to-back acceptance: in_ready goes high only in the cycle after the handshake.
- flush:
  - Has priority over everything, in every state.
  - Next state = IDLE, out_valid = 0, counter = 0. Any in-flight operation is discarded.
  - A request presented with flush high is not accepted.
- rst_n asserted mid-CALC: outputs immediately return to their reset values.
- in_valid while not IDLE is ignored. The requester must hold its request until in_ready is high.
- Operand values are captured only at accept; changes afterwards have no effect.

Test Plan:
- Signed 7/2:
  - is_rem=0 → result 0x0000000000000003 after exactly 32 CALC cycles.
  - is_rem=1 → 0x0000000000000001.
- Signed dividend 0xFFFFFFF9 (-7), divisor 2:
  - quotient → 0xFFFFFFFFFFFFFFFD.
  - remainder → 0xFFFFFFFFFFFFFFFF.
- Divide by zero, dividend 5, divisor 0:
  - out_valid 1 cycle after accept.
  - quotient 0xFFFFFFFFFFFFFFFF, remainder 0x0000000000000005.
- Signed overflow 0x80000000 / 0xFFFFFFFF:
  - 1-cycle latency.
  - quotient 0xFFFFFFFF80000000, remainder 0.
- Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFFFFFFFFFF. Unsigned 0x80000000 / 3 → quotient 0x000000002AAAAAAA, remainder 2.
- Control sequence:
  - Hold out_ready=0 for 5 cycles in DONE → result and out_valid stable, in_ready 0.
  - Separately, pulse flush on CALC cycle 10 → IDLE next cycle, out_valid never asserts, next request computes correctly.

Source files
------------

// File: rtl/ysyx_22040088_divider.sv
// Multi-cycle radix-2 restoring divider for the RV64 W-form divide/remainder ops.
// Results are sign-extended from bit WLEN-1, and requests and results use valid/ready handshakes.
module ysyx_22040088_divider #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned WLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            div_signed,
   input  logic            is_rem,
   input  logic [WLEN-1:0] dividend,
   input  logic [WLEN-1:0] divisor,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(WLEN);
   localparam logic [WLEN-1:0] INT_MIN = {1'b1, {(WLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [WLEN-1:0] rem_q, rem_d;
   logic [WLEN-1:0] quo_q, quo_d;
   logic [WLEN-1:0] dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            qsign_q, qsign_d;
   logic            rsign_q, rsign_d;
   logic            is_rem_q, is_rem_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [WLEN-1:0] mag_a, mag_b;
   logic [WLEN:0]   shifted;
   logic [WLEN+1:0] trial;
   logic [WLEN-1:0] step_rem, step_quo, fix_q, fix_r;

   function automatic logic [XLEN-1:0] sext(input logic [WLEN-1:0] v);
      return {{(XLEN-WLEN){v[WLEN-1]}}, v};
   endfunction

   always_comb begin
      mag_a = (div_signed && dividend[WLEN-1]) ? -dividend : dividend;
      mag_b = (div_signed && divisor[WLEN-1])  ? -divisor  : divisor;
      // The shifted partial remainder needs one extra bit when the divisor exceeds 2^(WLEN-1).
      // An extra sign bit on the trial difference keeps the borrow test unambiguous.
      shifted  = {rem_q, quo_q[WLEN-1]};
      trial    = {1'b0, shifted} - {2'b00, dvs_q};
      step_rem = trial[WLEN+1] ? shifted[WLEN-1:0] : trial[WLEN-1:0];
      step_quo = {quo_q[WLEN-2:0], ~trial[WLEN+1]};
      fix_q    = qsign_q ? -step_quo : step_quo;
      fix_r    = rsign_q ? -step_rem : step_rem;
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      qsign_d     = qsign_q;
      rsign_d     = rsign_q;
      is_rem_d    = is_rem_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               is_rem_d = is_rem;
               qsign_d  = div_signed & (dividend[WLEN-1] ^ divisor[WLEN-1]);
               rsign_d  = div_signed & dividend[WLEN-1];
               if (divisor == '0) begin
                  result_d    = sext(is_rem ? dividend : '1);
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else if (div_signed && dividend == INT_MIN && divisor == '1) begin
                  result_d    = sext(is_rem ? '0 : INT_MIN);
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = mag_a;
                  dvs_d   = mag_b;
                  cnt_d   = CW'(WLEN-1);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               result_d    = sext(is_rem_q ? fix_r : fix_q);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         qsign_q     <= 1'b0;
         rsign_q     <= 1'b0;
         is_rem_q    <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         qsign_q     <= qsign_d;
         rsign_q     <= rsign_d;
         is_rem_q    <= is_rem_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040088_divider.sv
// Directed bench for ysyx_22040088_divider: results, latency, output hold, flush and reset behaviour.
module tb_ysyx_22040088_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        div_signed = 1'b0;
   logic        is_rem = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] result;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   ysyx_22040088_divider #(.XLEN(64), .WLEN(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .div_signed (div_signed),
      .is_rem     (is_rem),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   // Latency counts edges from the accept edge through the first edge after which out_valid is high.
   task automatic run(input string tag, input logic sg, input logic rm,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp, input int lat, input int hold);
      int seen;
      seen = 0;
      @(negedge clk);
      check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
      div_signed = sg; is_rem = rm; dividend = a; divisor = b; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; dividend = 32'hDEAD_BEEF; divisor = '0;
      for (int i = 1; i <= 40 && seen == 0; i++) begin
         @(negedge clk);
         if (out_valid) seen = i;
      end
      check({tag, "/latency"}, 64'(seen), 64'(lat));
      check({tag, "/result"}, result, exp);
      if (seen != 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "/hold_ready"}, 64'(in_ready), 64'd0);
            check({tag, "/hold_result"}, result, exp);
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
         @(negedge clk);
         check({tag, "/valid_clr"}, 64'(out_valid), 64'd0);
         check({tag, "/ready_back"}, 64'(in_ready), 64'd1);
         check({tag, "/result_kept"}, result, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic        sg;
      logic        rm;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int vcount;

      vecs.push_back('{"s7/2q",      1'b1, 1'b0, 32'd7,         32'd2,         64'h0000000000000003, 33});
      vecs.push_back('{"s7/2r",      1'b1, 1'b1, 32'd7,         32'd2,         64'h0000000000000001, 33});
      vecs.push_back('{"s-7/2q",     1'b1, 1'b0, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFFFFFFFFFD, 33});
      vecs.push_back('{"s-7/2r",     1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFFFFFFFFFF, 33});
      vecs.push_back('{"s7/-2r",     1'b1, 1'b1, 32'd7,         32'hFFFFFFFE,  64'h0000000000000001, 33});
      vecs.push_back('{"div0q",      1'b1, 1'b0, 32'd5,         32'd0,         64'hFFFFFFFFFFFFFFFF, 1});
      vecs.push_back('{"div0r",      1'b1, 1'b1, 32'd5,         32'd0,         64'h0000000000000005, 1});
      vecs.push_back('{"ovfq",       1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF,  64'hFFFFFFFF80000000, 1});
      vecs.push_back('{"ovfr",       1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h0000000000000000, 1});
      vecs.push_back('{"uFFFF/1q",   1'b0, 1'b0, 32'hFFFFFFFF,  32'd1,         64'hFFFFFFFFFFFFFFFF, 33});
      vecs.push_back('{"u8000/3q",   1'b0, 1'b0, 32'h80000000,  32'd3,         64'h000000002AAAAAAA, 33});
      vecs.push_back('{"u8000/3r",   1'b0, 1'b1, 32'h80000000,  32'd3,         64'h0000000000000002, 33});
      vecs.push_back('{"u8000/FFFFr",1'b0, 1'b1, 32'h80000000,  32'hFFFFFFFF,  64'hFFFFFFFF80000000, 33});

      #12;
      check("rst/in_ready", 64'(in_ready), 64'd1);
      check("rst/out_valid", 64'(out_valid), 64'd0);
      check("rst/result", result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[k]) run(vecs[k].tag, vecs[k].sg, vecs[k].rm, vecs[k].a, vecs[k].b,
                            vecs[k].exp, vecs[k].lat, 0);

      run("hold100/7", 1'b1, 1'b0, 32'd100, 32'd7, 64'h000000000000000E, 33, 5);

      // Flush on the tenth CALC edge.
      @(negedge clk);
      div_signed = 1'b0; is_rem = 1'b0; dividend = 32'd1000; divisor = 32'd10; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("flush/busy", 64'(in_ready), 64'd0);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush/idle", 64'(in_ready), 64'd1);
      check("flush/valid", 64'(out_valid), 64'd0);
      flush = 1'b1; in_valid = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("flush/blocked_req", 64'(in_ready), 64'd1);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) vcount++;
      end
      check("flush/no_valid", 64'(vcount), 64'd0);
      run("postflush", 1'b0, 1'b0, 32'd1000, 32'd10, 64'h0000000000000064, 33, 0);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      div_signed = 1'b1; is_rem = 1'b0; dividend = 32'd50; divisor = 32'd5; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst/in_ready", 64'(in_ready), 64'd1);
      check("arst/out_valid", 64'(out_valid), 64'd0);
      check("arst/result", result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run("postrst", 1'b1, 1'b1, 32'd50, 32'd7, 64'h0000000000000001, 33, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
